// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB (or MDU) and drives the shared-datapath controls.
module mips_multicycle_controller #(
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               regwrite,
  output logic [1:0]         regdest,
  output logic [1:0]         memtoreg,
  output logic               hilo_sel,
  output logic               alusrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               is_sign,
  output logic               zero_extern,
  output logic               use_sa,
  output logic               mdu_start,
  output logic [1:0]         mdu_op,
  output logic               hilo_write,
  output logic               illegal,
  output logic [2:0]         state
);

  localparam int unsigned OP_W = 6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL,
    C_JR, C_JALR, C_MFHI, C_MFLO, C_MDU, C_ILL
  } cls_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] F_SLL   = 6'h00;
  localparam logic [OP_W-1:0] F_SRL   = 6'h02;
  localparam logic [OP_W-1:0] F_SRA   = 6'h03;
  localparam logic [OP_W-1:0] F_SLLV  = 6'h04;
  localparam logic [OP_W-1:0] F_SRLV  = 6'h06;
  localparam logic [OP_W-1:0] F_SRAV  = 6'h07;
  localparam logic [OP_W-1:0] F_JR    = 6'h08;
  localparam logic [OP_W-1:0] F_JALR  = 6'h09;
  localparam logic [OP_W-1:0] F_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] F_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] F_MULT  = 6'h18;
  localparam logic [OP_W-1:0] F_MULTU = 6'h19;
  localparam logic [OP_W-1:0] F_DIV   = 6'h1A;
  localparam logic [OP_W-1:0] F_DIVU  = 6'h1B;
  localparam logic [OP_W-1:0] F_ADD   = 6'h20;
  localparam logic [OP_W-1:0] F_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] F_SUB   = 6'h22;
  localparam logic [OP_W-1:0] F_SUBU  = 6'h23;
  localparam logic [OP_W-1:0] F_AND   = 6'h24;
  localparam logic [OP_W-1:0] F_OR    = 6'h25;
  localparam logic [OP_W-1:0] F_XOR   = 6'h26;
  localparam logic [OP_W-1:0] F_NOR   = 6'h27;
  localparam logic [OP_W-1:0] F_SLT   = 6'h2A;
  localparam logic [OP_W-1:0] F_SLTU  = 6'h2B;

  state_t           state_q, state_n;
  cls_t             cls;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic [OP_W-1:0]  opcode, funct;
  logic [3:0]       dec_aluop;
  logic             dec_alusrc, dec_is_sign, dec_zext, dec_use_sa;
  logic             unused_instr_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // register/immediate fields are routed by the datapath, not decoded here
  assign unused_instr_bits = ^instr[25:6];

  // Instruction class and EXEC-phase ALU controls
  always_comb begin
    cls         = C_ILL;
    dec_aluop   = ALU_ADD;
    dec_alusrc  = 1'b0;
    dec_is_sign = 1'b1;
    dec_zext    = 1'b0;
    dec_use_sa  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = C_ALU_R;
        case (funct)
          F_SLL:   begin dec_aluop = ALU_SLL; dec_use_sa = 1'b1; end
          F_SRL:   begin dec_aluop = ALU_SRL; dec_use_sa = 1'b1; end
          F_SRA:   begin dec_aluop = ALU_SRA; dec_use_sa = 1'b1; end
          F_SLLV:  dec_aluop = ALU_SLL;
          F_SRLV:  dec_aluop = ALU_SRL;
          F_SRAV:  dec_aluop = ALU_SRA;
          F_JR:    cls = C_JR;
          F_JALR:  cls = C_JALR;
          F_MFHI:  cls = C_MFHI;
          F_MFLO:  cls = C_MFLO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: cls = C_MDU;
          F_ADD:   dec_aluop = ALU_ADD;
          F_ADDU:  dec_is_sign = 1'b0;
          F_SUB:   dec_aluop = ALU_SUB;
          F_SUBU:  begin dec_aluop = ALU_SUB; dec_is_sign = 1'b0; end
          F_AND:   dec_aluop = ALU_AND;
          F_OR:    dec_aluop = ALU_OR;
          F_XOR:   dec_aluop = ALU_XOR;
          F_NOR:   dec_aluop = ALU_NOR;
          F_SLT:   dec_aluop = ALU_SLT;
          F_SLTU:  begin dec_aluop = ALU_SLT; dec_is_sign = 1'b0; end
          default: cls = C_ILL;
        endcase
      end
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      OP_BEQ:   begin cls = C_BEQ; dec_aluop = ALU_SUB; end
      OP_BNE:   begin cls = C_BNE; dec_aluop = ALU_SUB; end
      OP_ADDI:  begin cls = C_ALU_I; dec_alusrc = 1'b1; end
      OP_ADDIU: begin cls = C_ALU_I; dec_alusrc = 1'b1; dec_is_sign = 1'b0; end
      OP_SLTI:  begin cls = C_ALU_I; dec_aluop = ALU_SLT; dec_alusrc = 1'b1; end
      OP_SLTIU: begin
        cls = C_ALU_I; dec_aluop = ALU_SLT; dec_alusrc = 1'b1; dec_is_sign = 1'b0;
      end
      OP_ANDI:  begin cls = C_ALU_I; dec_aluop = ALU_AND; dec_alusrc = 1'b1; dec_zext = 1'b1; end
      OP_ORI:   begin cls = C_ALU_I; dec_aluop = ALU_OR;  dec_alusrc = 1'b1; dec_zext = 1'b1; end
      OP_XORI:  begin cls = C_ALU_I; dec_aluop = ALU_XOR; dec_alusrc = 1'b1; dec_zext = 1'b1; end
      OP_LUI:   begin cls = C_ALU_I; dec_aluop = ALU_LUI; dec_alusrc = 1'b1; end
      OP_LW:    begin cls = C_LW; dec_alusrc = 1'b1; end
      OP_SW:    begin cls = C_SW; dec_alusrc = 1'b1; end
      default:  cls = C_ILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_n;
  end

  // MDU occupancy counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE && cls == C_MDU)
        cnt_q <= CNT_W'(MDU_CYCLES - 1);
      else if (state_q == S_MDU && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == S_DECODE && cls == C_ILL)
        illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_MDU:   state_n = S_MDU;
          C_ILL:   state_n = S_FETCH;
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_ALU_R, C_ALU_I, C_MFHI, C_MFLO: state_n = S_WB;
          C_LW, C_SW:                       state_n = S_MEM;
          default:                          state_n = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_n = (cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     state_n = S_FETCH;
      S_MDU:    if (cnt_q == '0) state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
  end

  // Output decode; reset forces the quiet FETCH vector
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    regwrite    = 1'b0;
    regdest     = 2'b00;
    memtoreg    = 2'b00;
    hilo_sel    = 1'b0;
    alusrc      = 1'b0;
    aluop       = '0;
    is_sign     = 1'b1;
    zero_extern = 1'b0;
    use_sa      = 1'b0;
    mdu_start   = 1'b0;
    mdu_op      = 2'b00;
    hilo_write  = 1'b0;
    illegal     = 1'b0;
    state       = S_FETCH;
    if (!rst) begin
      illegal = illegal_q;
      state   = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (cls == C_MDU) begin
            mdu_start = 1'b1;
            mdu_op    = instr[1:0];
          end
        end
        S_EXEC: begin
          aluop       = ALUOP_W'(dec_aluop);
          alusrc      = dec_alusrc;
          is_sign     = dec_is_sign;
          zero_extern = dec_zext;
          use_sa      = dec_use_sa;
          case (cls)
            C_BEQ:  begin pc_write = alu_zero;  pc_src = 2'b01; end
            C_BNE:  begin pc_write = !alu_zero; pc_src = 2'b01; end
            C_J:    begin pc_write = 1'b1; pc_src = 2'b10; end
            C_JAL:  begin
              pc_write = 1'b1; pc_src = 2'b10;
              regwrite = 1'b1; regdest = 2'b10; memtoreg = 2'b10;
            end
            C_JR:   begin pc_write = 1'b1; pc_src = 2'b11; end
            C_JALR: begin
              pc_write = 1'b1; pc_src = 2'b11;
              regwrite = 1'b1; regdest = 2'b01; memtoreg = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (cls == C_SW);
        end
        S_WB: begin
          regwrite = 1'b1;
          case (cls)
            C_LW:    memtoreg = 2'b01;
            C_MFHI:  begin regdest = 2'b01; memtoreg = 2'b11; hilo_sel = 1'b1; end
            C_MFLO:  begin regdest = 2'b01; memtoreg = 2'b11; end
            C_ALU_R: regdest = 2'b01;
            default: ;
          endcase
        end
        S_MDU:   hilo_write = (cnt_q == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomised bench for mips_multicycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control vectors.
module tb_mips_multicycle_controller;

  localparam int unsigned MDU_N = 4;
  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_MDU = 3'd5;

  logic clk = 1'b0;
  logic rst, mem_ready, alu_zero;
  logic [31:0] instr;
  logic mem_req, mem_we, iord, ir_load, pc_write, regwrite, hilo_sel, alusrc;
  logic is_sign, zero_extern, use_sa, mdu_start, hilo_write, illegal;
  logic [1:0] pc_src, regdest, memtoreg, mdu_op;
  logic [3:0] aluop;
  logic [2:0] state;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.ALUOP_W(4), .MDU_CYCLES(MDU_N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .regwrite(regwrite), .regdest(regdest),
    .memtoreg(memtoreg), .hilo_sel(hilo_sel), .alusrc(alusrc), .aluop(aluop),
    .is_sign(is_sign), .zero_extern(zero_extern), .use_sa(use_sa),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .hilo_write(hilo_write),
    .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_load, pc_write;
    logic [1:0] pc_src;
    logic       regwrite;
    logic [1:0] regdest, memtoreg;
    logic       hilo_sel, alusrc;
    logic [3:0] aluop;
    logic       is_sign, zero_extern, use_sa, mdu_start;
    logic [1:0] mdu_op;
    logic       hilo_write, illegal;
    logic [2:0] state;
  } out_t;

  typedef enum logic [3:0] {
    K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR,
    K_MFHI, K_MFLO, K_MDU, K_ILL
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] aop;
    logic       src, sgn, zx, sa, rdst;
  } info_t;

  out_t got;
  always_comb begin
    got             = '0;
    got.mem_req     = mem_req;     got.mem_we      = mem_we;
    got.iord        = iord;        got.ir_load     = ir_load;
    got.pc_write    = pc_write;    got.pc_src      = pc_src;
    got.regwrite    = regwrite;    got.regdest     = regdest;
    got.memtoreg    = memtoreg;    got.hilo_sel    = hilo_sel;
    got.alusrc      = alusrc;      got.aluop       = aluop;
    got.is_sign     = is_sign;     got.zero_extern = zero_extern;
    got.use_sa      = use_sa;      got.mdu_start   = mdu_start;
    got.mdu_op      = mdu_op;      got.hilo_write  = hilo_write;
    got.illegal     = illegal;     got.state       = state;
  end

  int   n_checks = 0;
  int   n_errors = 0;
  logic ill_flag;
  out_t  exp_q[$];
  logic  mr_q[$];
  string tag_q[$];

  logic [5:0] r_fn [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                            6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] i_op [14] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Mnemonic-level meaning of an instruction word
  function automatic info_t classify(input logic [31:0] w);
    info_t d;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    d = '{kind: K_ILL, aop: 4'd0, src: 1'b0, sgn: 1'b1, zx: 1'b0, sa: 1'b0, rdst: 1'b0};
    if (op == 6'h00) begin
      d.kind = K_ALU;
      d.rdst = 1'b1;
      case (fn)
        6'h00: begin d.aop = 4'd7; d.sa = 1'b1; end
        6'h02: begin d.aop = 4'd8; d.sa = 1'b1; end
        6'h03: begin d.aop = 4'd9; d.sa = 1'b1; end
        6'h04: d.aop = 4'd7;
        6'h06: d.aop = 4'd8;
        6'h07: d.aop = 4'd9;
        6'h08: d.kind = K_JR;
        6'h09: d.kind = K_JALR;
        6'h10: d.kind = K_MFHI;
        6'h12: d.kind = K_MFLO;
        6'h18, 6'h19, 6'h1A, 6'h1B: d.kind = K_MDU;
        6'h20: d.aop = 4'd0;
        6'h21: d.sgn = 1'b0;
        6'h22: d.aop = 4'd1;
        6'h23: begin d.aop = 4'd1; d.sgn = 1'b0; end
        6'h24: d.aop = 4'd2;
        6'h25: d.aop = 4'd3;
        6'h26: d.aop = 4'd4;
        6'h27: d.aop = 4'd5;
        6'h2A: d.aop = 4'd6;
        6'h2B: begin d.aop = 4'd6; d.sgn = 1'b0; end
        default: d.kind = K_ILL;
      endcase
    end else begin
      case (op)
        6'h02: d.kind = K_J;
        6'h03: d.kind = K_JAL;
        6'h04: begin d.kind = K_BEQ; d.aop = 4'd1; end
        6'h05: begin d.kind = K_BNE; d.aop = 4'd1; end
        6'h08: begin d.kind = K_ALU; d.src = 1'b1; end
        6'h09: begin d.kind = K_ALU; d.src = 1'b1; d.sgn = 1'b0; end
        6'h0A: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd6; end
        6'h0B: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd6; d.sgn = 1'b0; end
        6'h0C: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd2; d.zx = 1'b1; end
        6'h0D: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd3; d.zx = 1'b1; end
        6'h0E: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd4; d.zx = 1'b1; end
        6'h0F: begin d.kind = K_ALU; d.src = 1'b1; d.aop = 4'd10; end
        6'h23: begin d.kind = K_LW; d.src = 1'b1; end
        6'h2B: begin d.kind = K_SW; d.src = 1'b1; end
        default: d.kind = K_ILL;
      endcase
    end
    return d;
  endfunction

  function automatic out_t base(input logic [2:0] st);
    out_t o;
    o         = '0;
    o.is_sign = 1'b1;
    o.illegal = ill_flag;
    o.state   = st;
    return o;
  endfunction

  task automatic push(input logic mr, input out_t o, input string t);
    mr_q.push_back(mr);
    exp_q.push_back(o);
    tag_q.push_back(t);
  endtask

  // Expand one instruction into expected per-cycle vectors and mem_ready drive
  task automatic plan(input logic [31:0] w, input int fst, input int mst, input logic az);
    info_t d;
    out_t  o;
    d = classify(w);
    instr    = w;
    alu_zero = az;
    for (int i = 0; i < fst; i++) begin
      o = base(ST_FETCH); o.mem_req = 1'b1;
      push(1'b0, o, $sformatf("fetch_wait@%08h", w));
    end
    o = base(ST_FETCH); o.mem_req = 1'b1; o.ir_load = 1'b1; o.pc_write = 1'b1;
    push(1'b1, o, $sformatf("fetch@%08h", w));
    o = base(ST_DECODE);
    if (d.kind == K_MDU) begin o.mdu_start = 1'b1; o.mdu_op = w[1:0]; end
    push(rbit(), o, $sformatf("decode@%08h", w));
    if (d.kind == K_ILL) begin
      ill_flag = 1'b1;
      return;
    end
    if (d.kind == K_MDU) begin
      for (int unsigned k = 0; k < MDU_N; k++) begin
        o = base(ST_MDU); o.hilo_write = (k == MDU_N - 1);
        push(rbit(), o, $sformatf("mdu%0d@%08h", k, w));
      end
      return;
    end
    o = base(ST_EXEC);
    o.aluop = d.aop; o.alusrc = d.src; o.is_sign = d.sgn;
    o.zero_extern = d.zx; o.use_sa = d.sa;
    case (d.kind)
      K_BEQ:  begin o.pc_write = az;  o.pc_src = 2'b01; end
      K_BNE:  begin o.pc_write = !az; o.pc_src = 2'b01; end
      K_J:    begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      K_JAL:  begin
        o.pc_write = 1'b1; o.pc_src = 2'b10;
        o.regwrite = 1'b1; o.regdest = 2'b10; o.memtoreg = 2'b10;
      end
      K_JR:   begin o.pc_write = 1'b1; o.pc_src = 2'b11; end
      K_JALR: begin
        o.pc_write = 1'b1; o.pc_src = 2'b11;
        o.regwrite = 1'b1; o.regdest = 2'b01; o.memtoreg = 2'b10;
      end
      default: ;
    endcase
    push(rbit(), o, $sformatf("exec@%08h", w));
    if (d.kind == K_LW || d.kind == K_SW) begin
      for (int i = 0; i <= mst; i++) begin
        o = base(ST_MEM); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (d.kind == K_SW);
        push(i == mst, o, $sformatf("mem%0d@%08h", i, w));
      end
    end
    if (d.kind == K_ALU || d.kind == K_LW || d.kind == K_MFHI || d.kind == K_MFLO) begin
      o = base(ST_WB); o.regwrite = 1'b1;
      if (d.kind == K_LW) o.memtoreg = 2'b01;
      else o.regdest = {1'b0, d.rdst};
      if (d.kind == K_MFHI || d.kind == K_MFLO) begin
        o.memtoreg = 2'b11;
        o.hilo_sel = (d.kind == K_MFHI);
      end
      push(rbit(), o, $sformatf("wb@%08h", w));
    end
  endtask

  task automatic run_steps(input int n);
    out_t  e;
    string t;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      mem_ready = mr_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      check(t, 64'(got), 64'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [31:0] w, input int fst, input int mst, input logic az);
    plan(w, fst, mst, az);
    run_steps(exp_q.size());
  endtask

  initial begin
    out_t rv;
    rst = 1'b1; instr = '0; mem_ready = 1'b1; alu_zero = 1'b0; ill_flag = 1'b0;
    rv = base(ST_FETCH);
    @(posedge clk);
    @(negedge clk);
    check("reset", 64'(got), 64'(rv));
    @(posedge clk);
    #1 rst = 1'b0;

    do_instr(32'h00221821, 0, 0, 1'b0);   // addu
    do_instr(32'h8C220004, 0, 3, 1'b0);   // lw, three memory stalls
    do_instr(32'h10220003, 0, 0, 1'b1);   // beq taken
    do_instr(32'h10220003, 0, 0, 1'b0);   // beq not taken
    do_instr(32'h0C000010, 0, 0, 1'b0);   // jal
    do_instr(32'h00220018, 0, 0, 1'b0);   // mult
    do_instr(32'h00001810, 0, 0, 1'b0);   // mfhi
    do_instr(32'hAC220008, 2, 1, 1'b0);   // sw with fetch and memory stalls

    for (int n = 0; n < 250; n++) begin
      logic [31:0] w;
      int unsigned sel, idx;
      sel = $urandom_range(0, 99);
      if (sel < 8) w = $urandom();
      else if (sel < 55) begin
        idx = $urandom_range(0, 23);
        w = {6'h00, 20'($urandom()), r_fn[idx]};
      end else begin
        idx = $urandom_range(0, 13);
        w = {i_op[idx], 26'($urandom())};
      end
      do_instr(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rbit());
    end

    // Unsupported opcode makes illegal sticky, then reset lands in sw's MEM
    do_instr(32'hFC000000, 0, 0, 1'b0);
    do_instr(32'h00221821, 1, 0, 1'b0);
    plan(32'hAC220008, 0, 4, 1'b0);
    run_steps(3);
    exp_q.delete(); mr_q.delete(); tag_q.delete();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_in_mem", 64'(got), 64'(rv));
    @(posedge clk);
    #1 rst = 1'b0;
    ill_flag = 1'b0;
    do_instr(32'h00221821, 0, 0, 1'b0);
    do_instr(32'h8C220004, 1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
